// File: rtl/mul_iter.sv
// Iterative 32x32->64 shift-add multiplier with valid/ready result handshake.
// Define MUL_RADIX4_EN to retire two multiplier bits per RUN cycle (16 iterations instead of 32).
module mul_iter (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Start,
    input  logic [5:0]  Func,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        Ready,
    output logic        Busy,
    output logic        Valid,
    output logic [63:0] Out,
    output logic [5:0]  FuncOut,
    output logic        ACCEn
);

`ifdef MUL_RADIX4_EN
    localparam int unsigned NumIter = 16;
    localparam int unsigned Step    = 2;
`else
    localparam int unsigned NumIter = 32;
    localparam int unsigned Step    = 1;
`endif

    localparam logic [5:0] FnMadd  = 6'b000000;
    localparam logic [5:0] FnMaddu = 6'b000001;
    localparam logic [5:0] FnMsub  = 6'b000100;
    localparam logic [5:0] FnMsubu = 6'b000101;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] prod_q;
    logic        neg_q;
    logic [5:0]  func_q;
    logic [63:0] out_q;
    logic [5:0]  func_out_q;
    logic        accen_q;
    logic        busy_q;
    logic        valid_q;

    logic        accept;
    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] addend;
    logic [63:0] prod_fix;
    logic        is_acc;

    always_comb begin
        accept    = Start && !Flush &&
                    ((state_q == StIdle) || ((state_q == StDone) && Ready));
        op_signed = ~Func[0];
        mag_a     = (op_signed && A[31]) ? (~A + 32'd1) : A;
        mag_b     = (op_signed && B[31]) ? (~B + 32'd1) : B;
`ifdef MUL_RADIX4_EN
        addend = '0;
        unique case (mplier_q[1:0])
            2'd0: addend = '0;
            2'd1: addend = mcand_q;
            2'd2: addend = mcand_q << 1;
            2'd3: addend = mcand_q + (mcand_q << 1);
        endcase
`else
        addend = mplier_q[0] ? mcand_q : '0;
`endif
        prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;
        is_acc   = 1'b0;
        case (func_q)
            FnMadd, FnMaddu, FnMsub, FnMsubu: is_acc = 1'b1;
            default:                          is_acc = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            neg_q      <= 1'b0;
            func_q     <= '0;
            out_q      <= '0;
            func_out_q <= '0;
            accen_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else if (Flush) begin
            // Result registers keep their last values; only the handshake is dropped.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            state_q  <= StRun;
            func_q   <= Func;
            mcand_q  <= {32'd0, mag_a};
            mplier_q <= mag_b;
            prod_q   <= '0;
            neg_q    <= op_signed && (A[31] ^ B[31]);
            cnt_q    <= 6'(NumIter);
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    // Counter reaching zero costs one extra RUN cycle before FIX.
                    if (cnt_q == 6'd0) begin
                        state_q <= StFix;
                    end else begin
                        prod_q   <= prod_q + addend;
                        mcand_q  <= mcand_q << Step;
                        mplier_q <= mplier_q >> Step;
                        cnt_q    <= cnt_q - 6'd1;
                    end
                end
                StFix: begin
                    out_q      <= prod_fix;
                    func_out_q <= func_q;
                    accen_q    <= is_acc;
                    busy_q     <= 1'b0;
                    valid_q    <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    if (Ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Valid   = valid_q;
    assign Out     = out_q;
    assign FuncOut = func_out_q;
    assign ACCEn   = accen_q;

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: vector table plus back-to-back, flush and reset sequences.
module tb_mul_iter;

`ifdef MUL_RADIX4_EN
    localparam int Lat = 18;
`else
    localparam int Lat = 34;
`endif

    logic        Clock;
    logic        nReset;
    logic        Start;
    logic [5:0]  Func;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Ready;
    logic        Busy;
    logic        Valid;
    logic [63:0] Out;
    logic [5:0]  FuncOut;
    logic        ACCEn;

    int n_vec = 0;
    int n_err = 0;

    mul_iter dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Start   (Start),
        .Func    (Func),
        .A       (A),
        .B       (B),
        .Flush   (Flush),
        .Ready   (Ready),
        .Busy    (Busy),
        .Valid   (Valid),
        .Out     (Out),
        .FuncOut (FuncOut),
        .ACCEn   (ACCEn)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_out;
        logic        exp_acc;
        int          stall;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: presents the op, lets one posedge accept it.
    task automatic accept_op(input string name, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b);
        Start = 1'b1;
        Func  = f;
        A     = a;
        B     = b;
        @(negedge Clock);
        Start = 1'b0;
        chk({name, " busy after accept"}, 64'(Busy), 64'd1);
        chk({name, " valid after accept"}, 64'(Valid), 64'd0);
    endtask

    task automatic wait_valid(input string name);
        int lat;
        lat = 0;
        while (!Valid && lat < 200) begin
            @(negedge Clock);
            lat++;
            if (Busy && Valid) chk({name, " busy/valid overlap"}, 64'd1, 64'd0);
        end
        chk({name, " latency"}, 64'(lat), 64'(Lat));
    endtask

    task automatic check_result(input string name, input logic [63:0] eo, input logic ea,
                                input logic [5:0] ef);
        chk({name, " valid"}, 64'(Valid), 64'd1);
        chk({name, " busy"}, 64'(Busy), 64'd0);
        chk({name, " out"}, Out, eo);
        chk({name, " accen"}, 64'(ACCEn), 64'(ea));
        chk({name, " funcout"}, 64'(FuncOut), 64'(ef));
    endtask

    task automatic no_valid_window(input string name, input int cycles);
        int seen_valid;
        int seen_busy;
        seen_valid = 0;
        seen_busy  = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge Clock);
            if (Valid) seen_valid++;
            if (Busy) seen_busy++;
        end
        chk({name, " no valid"}, 64'(seen_valid), 64'd0);
        chk({name, " no busy"}, 64'(seen_busy), 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, 0};
        vecs[1]  = '{6'b011000, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 1};
        vecs[2]  = '{6'b011000, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 1'b0, 0};
        vecs[3]  = '{6'b011001, 32'hFFFFFFFD, 32'h00000007, 64'h00000006FFFFFFEB, 1'b0, 2};
        vecs[4]  = '{6'b000000, 32'h00000005, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFB, 1'b1, 5};
        vecs[5]  = '{6'b000101, 32'h00000002, 32'h00000003, 64'h0000000000000006, 1'b1, 0};
        vecs[6]  = '{6'b000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 1'b0, 0};
        vecs[7]  = '{6'b000100, 32'h12345678, 32'h00000010, 64'h0000000123456780, 1'b1, 1};
        vecs[8]  = '{6'b111110, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA, 1'b0, 0};
        vecs[9]  = '{6'b011000, 32'h00000000, 32'h80000000, 64'h0000000000000000, 1'b0, 0};
        vecs[10] = '{6'b000001, 32'h80000000, 32'h00000002, 64'h0000000100000000, 1'b1, 0};
        vecs[11] = '{6'b011000, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, 1'b0, 0};

        nReset = 1'b0;
        Start  = 1'b0;
        Func   = '0;
        A      = '0;
        B      = '0;
        Flush  = 1'b0;
        Ready  = 1'b0;
        repeat (2) @(negedge Clock);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset valid", 64'(Valid), 64'd0);
        chk("reset out", Out, 64'd0);
        chk("reset funcout", 64'(FuncOut), 64'd0);
        chk("reset accen", 64'(ACCEn), 64'd0);
        nReset = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            accept_op(nm, vecs[i].func, vecs[i].a, vecs[i].b);
            wait_valid(nm);
            check_result(nm, vecs[i].exp_out, vecs[i].exp_acc, vecs[i].func);
            for (int s = 0; s < vecs[i].stall; s++) begin
                @(negedge Clock);
                check_result($sformatf("%s stall%0d", nm, s), vecs[i].exp_out,
                             vecs[i].exp_acc, vecs[i].func);
            end
            Ready = 1'b1;
            @(negedge Clock);
            Ready = 1'b0;
            chk({nm, " valid after ready"}, 64'(Valid), 64'd0);
            chk({nm, " busy after ready"}, 64'(Busy), 64'd0);
        end

        // Back-to-back accept from DONE, with a Start pulsed mid-RUN that must be ignored.
        accept_op("b2b madd", 6'b000000, 32'h5, 32'hFFFFFFFF);
        wait_valid("b2b madd");
        check_result("b2b madd", 64'hFFFFFFFFFFFFFFFB, 1'b1, 6'b000000);
        Ready = 1'b1;
        accept_op("b2b msubu", 6'b000101, 32'h2, 32'h3);
        Ready = 1'b0;
        repeat (4) @(negedge Clock);
        Start = 1'b1;
        Func  = 6'b011001;
        A     = 32'h9;
        B     = 32'h9;
        @(negedge Clock);
        Start = 1'b0;
        chk("run start ignored busy", 64'(Busy), 64'd1);
        begin
            int lat;
            lat = 5;
            while (!Valid && lat < 200) begin
                @(negedge Clock);
                lat++;
            end
            chk("b2b msubu latency", 64'(lat), 64'(Lat));
        end
        check_result("b2b msubu", 64'd6, 1'b1, 6'b000101);
        Ready = 1'b1;
        @(negedge Clock);
        Ready = 1'b0;
        chk("b2b idle valid", 64'(Valid), 64'd0);
        no_valid_window("after b2b", 40);

        // Flush in RUN with a coincident Start.
        accept_op("flush op", 6'b011000, 32'h3, 32'h4);
        repeat (5) @(negedge Clock);
        Flush = 1'b1;
        Start = 1'b1;
        Func  = 6'b011001;
        A     = 32'h1;
        B     = 32'h1;
        @(negedge Clock);
        Flush = 1'b0;
        Start = 1'b0;
        chk("flush busy", 64'(Busy), 64'd0);
        chk("flush valid", 64'(Valid), 64'd0);
        chk("flush out kept", Out, 64'd6);
        chk("flush funcout kept", 64'(FuncOut), 64'(6'b000101));
        chk("flush accen kept", 64'(ACCEn), 64'd1);
        no_valid_window("after flush", 40);

        // Asynchronous reset at RUN cycle 10.
        accept_op("rst op", 6'b011000, 32'h7, 32'h9);
        repeat (9) @(negedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        chk("async rst busy", 64'(Busy), 64'd0);
        chk("async rst valid", 64'(Valid), 64'd0);
        chk("async rst out", Out, 64'd0);
        @(negedge Clock);
        nReset = 1'b1;
        no_valid_window("after rst", 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
